dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the CPU's load/store path and a slow word-organised data memory.
- Owns tag/valid/dirty arrays and the 32-bit block store.
- Stalls the CPU with BUSYWAIT on misses and sequences write-back and fetch transactions to memory.
- The CPU PC update is gated by BUSYWAIT (PC holds while it is high).

Parameters:
- ADDR_W, 8, CPU byte address width.
- INDEX_BITS, 3, index width; NUM_BLOCKS = 2**INDEX_BITS = 8.
- OFFSET_BITS, 2, byte offset within block; fixed at 2 (4-byte / 32-bit block).
- TAG_BITS, ADDR_W-INDEX_BITS-OFFSET_BITS = 3, derived, not overridable.

Ports:
- CLK  in  1  system clock, all state changes on posedge.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- READ  in  1  CPU load request.
- WRITE  in  1  CPU store request.
- ADDRESS  in  ADDR_W  CPU byte address {tag,index,offset}.
- WRITEDATA  in  8  store byte.
- READDATA  out  8  load byte.
- BUSYWAIT  out  1  CPU stall.
- MEM_READ  out  1  block fetch request.
- MEM_WRITE  out  1  block write-back request.
- MEM_ADDRESS  out  ADDR_W-OFFSET_BITS  block address {tag,index}.
- MEM_WRITEDATA  out  32  victim block.
- MEM_READDATA  in  32  fetched block.
- MEM_BUSYWAIT  in  1  memory busy.

Behaviour:
- Reset (RESET=0, async):
  - state=IDLE; all valid=0, dirty=0.
  - MEM_READ=MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0, BUSYWAIT=0.
  - Block/tag contents are don't-care.
  - Reset mid-transaction aborts immediately; memory sees the request drop in the same cycle.
- Hit: hit = valid[idx] && tag[idx]==ADDRESS tag; combinational, evaluated only in IDLE.
- Read hit:
  - READDATA = block[idx] byte[offset], combinational.
  - BUSYWAIT=0; zero-stall.
- Write hit:
  - BUSYWAIT=0.
  - On the posedge: byte[offset] of block[idx] = WRITEDATA, dirty[idx]=1.
- No access (READ=WRITE=0): BUSYWAIT=0, READDATA holds its last value.
- READ and WRITE both high is illegal; WRITE takes priority. Benches must not rely on it.
- BUSYWAIT = (state!=IDLE) || ((READ||WRITE) && !hit), combinational.
- The CPU holds ADDRESS, WRITEDATA, READ and WRITE stable while BUSYWAIT=1.
- FSM states IDLE, WRITEBACK, FETCH, ALLOCATE:
  - IDLE: on miss, if valid[idx]&&dirty[idx] go to WRITEBACK, else go to FETCH.
  - WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={tag[idx],idx}, MEM_WRITEDATA=block[idx]. Go to FETCH on the first posedge with MEM_BUSYWAIT=0.
  - FETCH: MEM_READ=1, MEM_ADDRESS={ADDRESS tag,idx}. Go to ALLOCATE on the first posedge with MEM_BUSYWAIT=0, capturing MEM_READDATA.
  - ALLOCATE: block[idx]=captured data, tag[idx]=ADDRESS tag, valid=1, dirty=0. Go to IDLE after 1 cycle; no memory request is asserted.
  - Back in IDLE the access hits; a store then performs the byte write and sets dirty.
- Memory contract:
  - Memory raises MEM_BUSYWAIT combinationally in the first cycle of a request.
  - Memory lowers MEM_BUSYWAIT in the final cycle, with MEM_READDATA valid in that cycle.
  - MEM_READ and MEM_WRITE are never both high.
  - Request signals stay constant for the whole transaction.
- Miss penalty: clean miss = mem latency + 2 cycles; dirty miss = 2×mem latency + 2 cycles.
- Byte order: offset 0 = bits [7:0] … offset 3 = bits [31:24].
- If READ/WRITE drops during a miss (not legal from the CPU), the fill still completes and the FSM returns to IDLE.

Decomposition:
- Shared package: FSM state encoding (IDLE=0, WRITEBACK=1, FETCH=2, ALLOCATE=3), width constants, byte-lane select helper. The CPU opcode constants also live in this package.
- One natural sub-module, dcache_array: tag/valid/dirty/block storage with async-clear of valid/dirty, byte-write port and block-fill port.
- The FSM stays in dcache_controller.

Test Plan:
- Cold read: reset, READ addr 0x14, memory returns 0xDDCCBBAA after 5 cycles.
  - BUSYWAIT high 7 cycles, READDATA=0xAA; MEM_ADDRESS=0x05.
  - A re-read then hits with 0 stall.
- Write hit: after the fill above, WRITE 0x17 data 0x5E.
  - No stall; dirty[5]=1; a read of 0x17 returns 0x5E.
- Dirty eviction: READ 0x34 (same index 5, tag 1).
  - WRITEBACK MEM_ADDRESS=0x05, data 0x5ECCBBAA; then FETCH MEM_ADDRESS=0x0D.
  - Total stall 12 cycles at 5-cycle memory.
- Write miss allocate: WRITE 0x41 data 0x77 on an invalid index 0.
  - Fetch then byte write; final block byte1=0x77, dirty[0]=1.
- Reset mid-FETCH: drop RESET two cycles into FETCH.
  - MEM_READ=0 and BUSYWAIT=0 immediately; all valid=0; the next read of 0x14 misses.
- Back-to-back hits: alternating loads/stores across 8 indices after warm-up.
  - BUSYWAIT never asserts; scoreboard matches a reference byte array.

Source files
------------

// File: rtl/dcache_controller_pkg.sv
// Shared types and constants for the direct-mapped data cache.
// Address split is {tag, index, offset}, with one 32-bit block per index.
// Holds the FSM state encoding, the CPU access kinds and a byte-lane helper.
package dcache_controller_pkg;

  localparam int ADDR_W      = 8;
  localparam int INDEX_BITS  = 3;
  localparam int OFFSET_BITS = 2;
  localparam int TAG_BITS    = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int NUM_BLOCKS  = 1 << INDEX_BITS;
  localparam int BLOCK_W     = 32;
  localparam int MEM_ADDR_W  = ADDR_W - OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  // CPU access kinds as seen by the cache (store wins if both strobes are high)
  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_LOAD  = 2'd1,
    ACC_STORE = 2'd2
  } cpu_op_t;

  // Byte lane of a block: offset 0 is bits [7:0], offset 3 is bits [31:24]
  function automatic logic [7:0] byte_sel(input logic [BLOCK_W-1:0] blk,
                                          input logic [OFFSET_BITS-1:0] off);
    return blk[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side bus of the data cache.
// master = cache controller view, slave = CPU/memory environment view.
// Signal names follow the CPU/memory contract directly.
interface dcache_controller_if;
  import dcache_controller_pkg::*;

  logic                  READ;
  logic                  WRITE;
  logic [ADDR_W-1:0]     ADDRESS;
  logic [7:0]            WRITEDATA;
  logic [7:0]            READDATA;
  logic                  BUSYWAIT;
  logic                  MEM_READ;
  logic                  MEM_WRITE;
  logic [MEM_ADDR_W-1:0] MEM_ADDRESS;
  logic [BLOCK_W-1:0]    MEM_WRITEDATA;
  logic [BLOCK_W-1:0]    MEM_READDATA;
  logic                  MEM_BUSYWAIT;

  modport master (
    input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport slave (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/block storage for the direct-mapped cache.
// Reads are combinational on idx; writes land on the clock edge.
// valid/dirty clear asynchronously on reset; tags and data are left as-is.
module dcache_array
  import dcache_controller_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [INDEX_BITS-1:0]  idx,
  output logic [TAG_BITS-1:0]    tag_out,
  output logic                   valid_out,
  output logic                   dirty_out,
  output logic [BLOCK_W-1:0]     block_out,
  input  logic                   wr_byte_en,
  input  logic [OFFSET_BITS-1:0] wr_off,
  input  logic [7:0]             wr_byte,
  input  logic                   fill_en,
  input  logic [TAG_BITS-1:0]    fill_tag,
  input  logic [BLOCK_W-1:0]     fill_data
);

  logic [NUM_BLOCKS-1:0] valid;
  logic [NUM_BLOCKS-1:0] dirty;
  logic [TAG_BITS-1:0]   tags   [0:NUM_BLOCKS-1];
  logic [BLOCK_W-1:0]    blocks [0:NUM_BLOCKS-1];

  assign tag_out   = tags[idx];
  assign valid_out = valid[idx];
  assign dirty_out = dirty[idx];
  assign block_out = blocks[idx];

  // Line state: a fill makes the line valid and clean, a byte store dirties it
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (wr_byte_en) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Tag and data storage: whole-block fill or single-byte store
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      blocks[idx] <= fill_data;
      tags[idx]   <= fill_tag;
    end else if (wr_byte_en) begin
      blocks[idx][{wr_off, 3'b000} +: 8] <= wr_byte;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Hits are zero-stall; a miss stalls for mem latency + 2 (clean) or 2x + 2 (dirty).
// BUSYWAIT holds the CPU during misses; MEM_BUSYWAIT stretches each memory phase.
module dcache_controller
  import dcache_controller_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  dcache_controller_if.master bus
);

  state_t                  state;
  logic                    mem_read;
  logic                    mem_write;
  logic [MEM_ADDR_W-1:0]   mem_addr;
  logic [BLOCK_W-1:0]      mem_wdata;
  logic [BLOCK_W-1:0]      fill_q;
  logic [7:0]              readdata_q;

  logic [TAG_BITS-1:0]     addr_tag;
  logic [INDEX_BITS-1:0]   addr_idx;
  logic [OFFSET_BITS-1:0]  addr_off;
  logic [TAG_BITS-1:0]     line_tag;
  logic                    line_valid;
  logic                    line_dirty;
  logic [BLOCK_W-1:0]      line_block;
  cpu_op_t                 op;
  logic                    in_idle;
  logic                    hit;
  logic                    load_hit;
  logic                    store_hit;
  logic                    miss;

  assign addr_tag = bus.ADDRESS[ADDR_W-1 -: TAG_BITS];
  assign addr_idx = bus.ADDRESS[OFFSET_BITS +: INDEX_BITS];
  assign addr_off = bus.ADDRESS[OFFSET_BITS-1:0];

  assign op = bus.WRITE ? ACC_STORE : (bus.READ ? ACC_LOAD : ACC_NONE);

  assign in_idle   = (state == IDLE);
  assign hit       = line_valid && (line_tag == addr_tag);
  assign load_hit  = in_idle && (op == ACC_LOAD) && hit;
  assign store_hit = in_idle && (op == ACC_STORE) && hit;
  assign miss      = in_idle && (op != ACC_NONE) && !hit;

  // Stall and load data are combinational so hits cost no cycles; forced low in reset
  assign bus.BUSYWAIT      = RESET && (!in_idle || ((op != ACC_NONE) && !hit));
  assign bus.READDATA      = (RESET && load_hit) ? byte_sel(line_block, addr_off) : readdata_q;
  assign bus.MEM_READ      = mem_read;
  assign bus.MEM_WRITE     = mem_write;
  assign bus.MEM_ADDRESS   = mem_addr;
  assign bus.MEM_WRITEDATA = mem_wdata;

  dcache_array u_array (
    .CLK        (CLK),
    .RESET      (RESET),
    .idx        (addr_idx),
    .tag_out    (line_tag),
    .valid_out  (line_valid),
    .dirty_out  (line_dirty),
    .block_out  (line_block),
    .wr_byte_en (store_hit),
    .wr_off     (addr_off),
    .wr_byte    (bus.WRITEDATA),
    .fill_en    (state == ALLOCATE),
    .fill_tag   (addr_tag),
    .fill_data  (fill_q)
  );

  // Miss sequencer: optional victim write-back, block fetch, then one-cycle allocate
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      fill_q     <= '0;
      readdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_hit) readdata_q <= byte_sel(line_block, addr_off);
          if (miss) begin
            if (line_valid && line_dirty) begin
              state     <= WRITEBACK;
              mem_write <= 1'b1;
              mem_addr  <= {line_tag, addr_idx};
              mem_wdata <= line_block;
            end else begin
              state    <= FETCH;
              mem_read <= 1'b1;
              mem_addr <= {addr_tag, addr_idx};
            end
          end
        end
        WRITEBACK: begin
          if (!bus.MEM_BUSYWAIT) begin
            state     <= FETCH;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_addr  <= {addr_tag, addr_idx};
          end
        end
        FETCH: begin
          if (!bus.MEM_BUSYWAIT) begin
            state    <= ALLOCATE;
            mem_read <= 1'b0;
            fill_q   <= bus.MEM_READDATA;
          end
        end
        ALLOCATE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a 5-cycle word memory model.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
// Every expected value below is hand-derived from the address split and memory image.
module tb_dcache_controller;

  localparam int LAT = 5;

  logic CLK = 1'b0;
  logic RESET;
  int   errors = 0;
  int   checks = 0;

  dcache_controller_if bus ();

  dcache_controller dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Memory model: busy for LAT-1 cycles, done in the LAT-th, writes commit at its end
  logic [31:0] mem [0:63];
  logic        mem_ready = 1'b0;
  int          mcnt = 0;

  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++)
        mem[i] <= {8'(i + 8'h30), 8'(i + 8'h20), 8'(i + 8'h10), 8'(i)};
      mem[5]    <= 32'hDDCCBBAA;
      mem[13]   <= 32'h0D0C0B0A;
      mem[16]   <= 32'h44332211;
      mem_ready <= 1'b1;
      mcnt      <= 0;
    end else if (bus.MEM_READ || bus.MEM_WRITE) begin
      if (mcnt == LAT - 1) begin
        mcnt <= 0;
        if (bus.MEM_WRITE) mem[bus.MEM_ADDRESS] <= bus.MEM_WRITEDATA;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  assign bus.MEM_BUSYWAIT = (bus.MEM_READ || bus.MEM_WRITE) && (mcnt != LAT - 1);
  assign bus.MEM_READDATA = mem[bus.MEM_ADDRESS];

  // Bus monitor: remember the last request seen and any illegal read+write overlap
  logic [5:0]  last_wb_addr = '0;
  logic [31:0] last_wb_data = '0;
  logic [5:0]  last_rd_addr = '0;
  int          both_high = 0;

  always @(negedge CLK) begin
    if (bus.MEM_WRITE) begin
      last_wb_addr <= bus.MEM_ADDRESS;
      last_wb_data <= bus.MEM_WRITEDATA;
    end
    if (bus.MEM_READ) last_rd_addr <= bus.MEM_ADDRESS;
    if (bus.MEM_READ && bus.MEM_WRITE) both_high <= both_high + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One CPU access: drive, count stalled negedges, return the hit-cycle READDATA
  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, output int stalls, output logic [7:0] rdata);
    @(posedge CLK);
    #1;
    bus.READ      = rd;
    bus.WRITE     = wr;
    bus.ADDRESS   = a;
    bus.WRITEDATA = d;
    stalls = 0;
    @(negedge CLK);
    while (bus.BUSYWAIT && stalls < 64) begin
      stalls++;
      @(negedge CLK);
    end
    rdata = bus.READDATA;
  endtask

  task automatic go_idle();
    @(posedge CLK);
    #1;
    bus.READ  = 1'b0;
    bus.WRITE = 1'b0;
  endtask

  logic [7:0] refb [0:31];

  initial begin
    int         st;
    logic [7:0] rd;
    logic [7:0] a;
    logic [7:0] d;

    RESET         = 1'b0;
    bus.READ      = 1'b0;
    bus.WRITE     = 1'b0;
    bus.ADDRESS   = '0;
    bus.WRITEDATA = '0;
    repeat (3) @(negedge CLK);

    // Reset state
    chk("rst_busywait",  {31'b0, bus.BUSYWAIT},  32'd0);
    chk("rst_mem_read",  {31'b0, bus.MEM_READ},  32'd0);
    chk("rst_mem_write", {31'b0, bus.MEM_WRITE}, 32'd0);
    chk("rst_mem_addr",  {26'b0, bus.MEM_ADDRESS}, 32'd0);
    chk("rst_mem_wdata", bus.MEM_WRITEDATA, 32'd0);
    chk("rst_readdata",  {24'b0, bus.READDATA},  32'd0);
    chk("rst_valid",     {24'b0, dut.u_array.valid}, 32'd0);
    RESET = 1'b1;

    // Cold read 0x14: tag 0, index 5, offset 0
    access(1'b1, 1'b0, 8'h14, 8'h00, st, rd);
    chk("cold_stall", st, 32'd7);
    chk("cold_data", {24'b0, rd}, 32'h0000_00AA);
    chk("cold_mem_addr", {26'b0, last_rd_addr}, 32'h05);
    access(1'b1, 1'b0, 8'h14, 8'h00, st, rd);
    chk("reread_stall", st, 32'd0);
    chk("reread_data", {24'b0, rd}, 32'h0000_00AA);

    // Write hit to offset 3 of the same block
    access(1'b0, 1'b1, 8'h17, 8'h5E, st, rd);
    chk("wrhit_stall", st, 32'd0);
    access(1'b1, 1'b0, 8'h17, 8'h00, st, rd);
    chk("wrhit_dirty5", {31'b0, dut.u_array.dirty[5]}, 32'd1);
    chk("wrhit_read_stall", st, 32'd0);
    chk("wrhit_read_data", {24'b0, rd}, 32'h0000_005E);
    go_idle();
    @(negedge CLK);
    chk("idle_hold_data", {24'b0, bus.READDATA}, 32'h0000_005E);
    chk("idle_busywait", {31'b0, bus.BUSYWAIT}, 32'd0);

    // Dirty eviction: 0x34 is tag 1, index 5
    access(1'b1, 1'b0, 8'h34, 8'h00, st, rd);
    chk("evict_stall", st, 32'd12);
    chk("evict_wb_addr", {26'b0, last_wb_addr}, 32'h05);
    chk("evict_wb_data", last_wb_data, 32'h5ECCBBAA);
    chk("evict_mem5", mem[5], 32'h5ECCBBAA);
    chk("evict_fetch_addr", {26'b0, last_rd_addr}, 32'h0D);
    chk("evict_data", {24'b0, rd}, 32'h0000_000A);
    chk("evict_clean5", {31'b0, dut.u_array.dirty[5]}, 32'd0);

    // Write miss allocate: 0x41 is tag 2, index 0, offset 1
    access(1'b0, 1'b1, 8'h41, 8'h77, st, rd);
    chk("wmiss_stall", st, 32'd7);
    chk("wmiss_fetch_addr", {26'b0, last_rd_addr}, 32'h10);
    access(1'b1, 1'b0, 8'h41, 8'h00, st, rd);
    chk("wmiss_read_b1", {24'b0, rd}, 32'h0000_0077);
    access(1'b1, 1'b0, 8'h40, 8'h00, st, rd);
    chk("wmiss_read_b0", {24'b0, rd}, 32'h0000_0011);
    chk("wmiss_block0", dut.u_array.blocks[0], 32'h44337711);
    chk("wmiss_dirty0", {31'b0, dut.u_array.dirty[0]}, 32'd1);
    go_idle();

    // Reset two cycles into FETCH of 0x14 (index 5 holds tag 1, clean)
    @(posedge CLK);
    #1;
    bus.READ    = 1'b1;
    bus.ADDRESS = 8'h14;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk("pre_rst_mem_read", {31'b0, bus.MEM_READ}, 32'd1);
    RESET = 1'b0;
    #1;
    chk("midrst_mem_read", {31'b0, bus.MEM_READ}, 32'd0);
    chk("midrst_busywait", {31'b0, bus.BUSYWAIT}, 32'd0);
    chk("midrst_valid", {24'b0, dut.u_array.valid}, 32'd0);
    @(posedge CLK);
    #1;
    bus.READ = 1'b0;
    RESET    = 1'b1;
    access(1'b1, 1'b0, 8'h14, 8'h00, st, rd);
    chk("postrst_miss_stall", st, 32'd7);
    chk("postrst_data", {24'b0, rd}, 32'h0000_00AA);

    // Warm all 8 indices with tag 0 and build the reference image from memory
    for (int i = 0; i < 8; i++) begin
      access(1'b1, 1'b0, {3'b000, 3'(i), 2'b00}, 8'h00, st, rd);
      chk("warm_data", {24'b0, rd}, {24'b0, mem[i][7:0]});
    end
    for (int i = 0; i < 32; i++) refb[i] = mem[i / 4][(i % 4) * 8 +: 8];

    // Back-to-back alternating stores and loads, all hits
    for (int k = 0; k < 32; k++) begin
      if (k % 2 == 0) begin
        a = {3'b000, 3'((k / 2) % 8), 2'((k / 2) / 4)};
        d = 8'(k * 13 + 7);
        access(1'b0, 1'b1, a, d, st, rd);
        refb[a[4:0]] = d;
        chk("b2b_store_stall", st, 32'd0);
      end else begin
        a = {3'b000, 3'((k * 3) % 8), 2'(k % 4)};
        access(1'b1, 1'b0, a, 8'h00, st, rd);
        chk("b2b_load_stall", st, 32'd0);
        chk("b2b_load_data", {24'b0, rd}, {24'b0, refb[a[4:0]]});
      end
    end
    // Read back every byte once more
    for (int i = 0; i < 32; i++) begin
      access(1'b1, 1'b0, 8'(i), 8'h00, st, rd);
      chk("final_data", {24'b0, rd}, {24'b0, refb[i]});
    end
    go_idle();
    @(negedge CLK);
    chk("never_both_req", both_high, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
